cuenta_1: RTL and testbench
===========================

# cuenta_1

Sequential ones-counter: on a start request it loads a 3-bit operand, examines it one bit per clock (LSB first), and accumulates the number of 1 bits into a 4-bit result. It signals completion with `fin`. Datapath:
- 4-bit incrementer (adder, +1, carry-in 0, carry-out unused);
- 4-bit accumulator register A, with clear and load;
- 3-bit right-shift register Q, with load and shift;
- Moore control FSM.

It is a leaf arithmetic block used as a multi-cycle bit-counting unit in the processor exercises.

## Interface
- Parameters: none (widths fixed: operand 3 bits, count 4 bits).
- `clk`  input  1  rising-edge clock; all state changes on this edge.
- `reset`  input  1  synchronous, active-high; one clock; reset sampled on `clk` rising edge.
- `Valor`  input  3  operand whose 1 bits are counted; sampled only on the load edge.
- `start`  input  1  level request; sampled on `clk` in IDLE and DONE only.
- `Cuenta`  output  4  accumulator A contents, driven continuously (wire from register).
- `fin`  output  1  completion flag, high exactly while FSM is in DONE.

## Operation
- FSM states: IDLE, BIT0, BIT1, BIT2, DONE.
- IDLE:
  - `fin`=0.
  - If `start`=1: Q <= `Valor`, A <= 0, go to BIT0.
  - Else: stay; A and Q hold.
- BIT0/BIT1/BIT2 (each one clock):
  - If Q[0]=1: A <= A + 1, else A holds.
  - Q <= {1'b0, Q[2:1]} (logical right shift, 0 enters MSB).
  - Next state: BIT0→BIT1→BIT2→DONE unconditionally.
  - `start` and `Valor` are ignored in these states.
- DONE:
  - `fin`=1; A and Q hold; `Cuenta` = number of 1s in the loaded `Valor` (0..3).
  - If `start`=0: go to IDLE.
  - If `start`=1: stay in DONE. A held-high `start` does not retrigger; a new operation needs `start` to fall and rise again.
- IDLE after DONE keeps the previous result on `Cuenta` until the next load clears A.
- Arithmetic: 4-bit unsigned increment, carry-out discarded. The result never exceeds 3, so no wrap occurs in normal operation.
- Reset (priority over all other inputs, any state): state <= IDLE, A <= 0, Q <= 0, so `Cuenta`=0 and `fin`=0 after the edge.

## Timing
- Reset values: `Cuenta`=4'b0000, `fin`=0, state IDLE.
- Let edge k be the edge where `start`=1 is sampled in IDLE:
  - After k: A=0 and `Cuenta`=0.
  - After edges k+1, k+2, k+3: bits 0, 1, 2 are accumulated.
  - After k+3: `fin`=1 and `Cuenta` is final.
  - Latency from start sample to `fin`: 3 cycles. Total busy time: 4 edges including the load edge.
- `fin` is registered (state-decoded Moore output), glitch-free, and stays high until the first edge where `start`=0 is sampled in DONE.
- Reset mid-operation aborts the count: IDLE after that edge, no `fin` pulse.
- Reset and `start` high on the same edge: reset wins; the FSM enters IDLE and loads nothing.
- `Valor` changes after the load edge do not affect the result.

## Test plan
- Assert `reset` for 2 cycles with `start`=1, `Valor`=3'b111 -> `Cuenta`=0, `fin`=0, no operation starts while reset is high.
- For each `Valor` 000..111: pulse `start` one cycle -> `fin` rises 3 cycles after the load edge with `Cuenta` = 0,1,1,2,1,2,2,3 respectively.
- `Valor`=3'b101, hold `start`=1 throughout -> `fin`=1 with `Cuenta`=2, stays in DONE with no recount. Then drop `start` -> `fin`=0 next edge, `Cuenta` stays 2.
- Load `Valor`=3'b011, then change `Valor` to 3'b000 during BIT0..BIT2 -> final `Cuenta`=2.
- `Valor`=3'b111, assert `reset` during BIT1 -> after that edge `Cuenta`=0, `fin`=0, state IDLE; a subsequent start yields `Cuenta`=3.
- Back-to-back ops: `Valor`=3'b111 then 3'b001 -> second load clears A, final `Cuenta`=1 (no residue from 3).

Source files
------------

// File: rtl/cuenta_1_if.sv
// Operand/result bundle for the cuenta_1 ones-counter.
// The master side drives the operand and start request.
// The slave side (the counter) returns the running count and the done flag.
interface cuenta_1_if;
    logic [2:0] Valor;
    logic       start;
    logic [3:0] Cuenta;
    logic       fin;

    modport master (
        output Valor,
        output start,
        input  Cuenta,
        input  fin
    );

    modport slave (
        input  Valor,
        input  start,
        output Cuenta,
        output fin
    );
endinterface

// File: rtl/cuenta_1.sv
// cuenta_1: sequential ones-counter.
// A start request loads a 3-bit operand into shift register Q and clears
// accumulator A. The block then spends one clock per operand bit, LSB first,
// and adds Q[0] into A through a 4-bit +1 incrementer. A Moore FSM
// sequences the work and raises fin while the result is held in DONE.
module cuenta_1 (
    input  logic       clk,
    input  logic       reset,
    cuenta_1_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIT0 = 3'd1,
        S_BIT1 = 3'd2,
        S_BIT2 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [3:0] r_acc;
    logic [2:0] r_q;

    logic       w_clr_a;
    logic       w_ld_q;
    logic       w_step;
    logic [3:0] w_inc;

    // 4-bit incrementer: carry-in 0, carry-out dropped.
    function automatic logic [3:0] inc4(input logic [3:0] a);
        logic [4:0] sum;
        sum  = {1'b0, a} + 5'd1;
        inc4 = sum[3:0];
    endfunction

    // Logical right shift by one; a zero enters the MSB.
    function automatic logic [2:0] shr3(input logic [2:0] q);
        shr3 = {1'b0, q[2:1]};
    endfunction

    assign w_inc = inc4(r_acc);

    // State register; reset overrides everything and returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next  = r_state;
        w_clr_a = 1'b0;
        w_ld_q  = 1'b0;
        w_step  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_clr_a = 1'b1;
                    w_ld_q  = 1'b1;
                    w_next  = S_BIT0;
                end
            end
            S_BIT0: begin
                w_step = 1'b1;
                w_next = S_BIT1;
            end
            S_BIT1: begin
                w_step = 1'b1;
                w_next = S_BIT2;
            end
            S_BIT2: begin
                w_step = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                // A held start must fall before another operation can begin.
                if (!bus.start) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Accumulator A: cleared on load, incremented when the current bit is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= 4'd0;
        end else if (w_clr_a) begin
            r_acc <= 4'd0;
        end else if (w_step && r_q[0]) begin
            r_acc <= w_inc;
        end
    end

    // Operand shift register Q: loaded on the start edge, shifted each bit step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 3'd0;
        end else if (w_ld_q) begin
            r_q <= bus.Valor;
        end else if (w_step) begin
            r_q <= shr3(r_q);
        end
    end

    assign bus.Cuenta = r_acc;
    assign bus.fin    = (r_state == S_DONE);

endmodule

// File: tb/tb_cuenta_1.sv
// Directed testbench for cuenta_1: inputs change on the falling edge and
// outputs are sampled on the following falling edge, half a cycle after
// the rising edge that updated them.
module tb_cuenta_1;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    cuenta_1_if bus ();

    cuenta_1 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-cycle start pulse; checks load, busy and done timing, then returns to IDLE.
    task automatic run_op(input logic [2:0] v, input logic [3:0] exp, input string tag);
        bus.Valor = v;
        bus.start = 1'b1;
        @(negedge clk);                          // edge k (load) has passed
        chk({tag, "_load_cnt"}, bus.Cuenta, 4'd0);
        chk({tag, "_load_fin"}, {3'b0, bus.fin}, 4'd0);
        bus.start = 1'b0;
        @(negedge clk);                          // after k+1
        chk({tag, "_k1_fin"}, {3'b0, bus.fin}, 4'd0);
        @(negedge clk);                          // after k+2
        chk({tag, "_k2_fin"}, {3'b0, bus.fin}, 4'd0);
        @(negedge clk);                          // after k+3
        chk({tag, "_done_fin"}, {3'b0, bus.fin}, 4'd1);
        chk({tag, "_done_cnt"}, bus.Cuenta, exp);
        @(negedge clk);                          // start low in DONE -> IDLE
        chk({tag, "_idle_fin"}, {3'b0, bus.fin}, 4'd0);
        chk({tag, "_idle_cnt"}, bus.Cuenta, exp);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.Valor = 3'b111;

        // Reset held two cycles with start high: nothing may begin.
        @(negedge clk);
        chk("rst1_cnt", bus.Cuenta, 4'd0);
        chk("rst1_fin", {3'b0, bus.fin}, 4'd0);
        @(negedge clk);
        chk("rst2_cnt", bus.Cuenta, 4'd0);
        chk("rst2_fin", {3'b0, bus.fin}, 4'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_fin", {3'b0, bus.fin}, 4'd0);
        end
        chk("post_rst_cnt", bus.Cuenta, 4'd0);

        // Every operand value.
        run_op(3'b000, 4'd0, "v000");
        run_op(3'b001, 4'd1, "v001");
        run_op(3'b010, 4'd1, "v010");
        run_op(3'b011, 4'd2, "v011");
        run_op(3'b100, 4'd1, "v100");
        run_op(3'b101, 4'd2, "v101");
        run_op(3'b110, 4'd2, "v110");
        run_op(3'b111, 4'd3, "v111");

        // Start held high: finishes once, stays in DONE, no recount.
        bus.Valor = 3'b101;
        bus.start = 1'b1;
        repeat (4) @(negedge clk);
        chk("hold_fin", {3'b0, bus.fin}, 4'd1);
        chk("hold_cnt", bus.Cuenta, 4'd2);
        repeat (5) @(negedge clk);
        chk("hold_stay_fin", {3'b0, bus.fin}, 4'd1);
        chk("hold_stay_cnt", bus.Cuenta, 4'd2);
        bus.start = 1'b0;
        @(negedge clk);
        chk("hold_drop_fin", {3'b0, bus.fin}, 4'd0);
        chk("hold_drop_cnt", bus.Cuenta, 4'd2);

        // Operand changed after the load edge has no effect.
        bus.Valor = 3'b011;
        bus.start = 1'b1;
        @(negedge clk);
        bus.Valor = 3'b000;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("valchg_fin", {3'b0, bus.fin}, 4'd1);
        chk("valchg_cnt", bus.Cuenta, 4'd2);
        @(negedge clk);
        chk("valchg_idle_fin", {3'b0, bus.fin}, 4'd0);

        // Reset during BIT1 aborts the count; no fin pulse follows.
        bus.Valor = 3'b111;
        bus.start = 1'b1;
        @(negedge clk);                          // in BIT0
        bus.start = 1'b0;
        @(negedge clk);                          // in BIT1, A = 1
        chk("abort_mid_cnt", bus.Cuenta, 4'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cnt", bus.Cuenta, 4'd0);
        chk("abort_fin", {3'b0, bus.fin}, 4'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_nopulse_fin", {3'b0, bus.fin}, 4'd0);
        end
        chk("abort_idle_cnt", bus.Cuenta, 4'd0);
        run_op(3'b111, 4'd3, "after_abort");

        // Back-to-back: second load clears the previous result.
        run_op(3'b111, 4'd3, "b2b_a");
        run_op(3'b001, 4'd1, "b2b_b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
